// File: rtl/rv_cpu_pkg.sv
// rv_cpu_pkg: shared opcode, funct3/funct7 constants and ALU operation encoding
// No ports; imported by rv_alu and rv_cpu_core.
package rv_cpu_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;
endpackage

// File: rtl/rv_alu.sv
// rv_alu: 32-bit combinational ALU
// Ports: a, b operands; op operation (alu_op_e encoding); y result; zero set when y == 0.
module rv_alu
    import rv_cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] y,
    output logic        zero
);
    assign y = op == ALU_SUB ? a - b :
               op == ALU_AND ? a & b :
               op == ALU_OR  ? a | b :
               op == ALU_XOR ? a ^ b :
               op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
                               a + b;
    assign zero = y == 32'b0;
endmodule

// File: rtl/rv_cpu_core.sv
// rv_cpu_core: single-cycle RV32I-subset CPU running a fixed ROM program
// Ports: clk rising-edge clock; reset async active-low; out registered x30[9:0].
module rv_cpu_core
    import rv_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] out
);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q, pc_d, instr, rs1_v, rs2_v, alu_b, alu_y, wb, rdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [DMEM_WORDS];
    logic [9:0]  out_q;
    logic [5:0]  iidx;
    logic [DW-1:0] didx;
    logic [6:0]  opc, f7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        rf_we, dm_we, zero;
    alu_op_e     alu_op;

    function automatic logic [31:0] rom_word(input logic [5:0] i);
        case (i)
            6'd0:    return 32'h00000093;
            6'd1:    return 32'h00100113;
            6'd2:    return 32'h00B00193;
            6'd3:    return 32'h002080B3;
            6'd4:    return 32'h00110113;
            6'd5:    return 32'h00008F33;
            6'd6:    return 32'hFE311AE3;
            6'd7:    return 32'h00102023;
            6'd8:    return 32'h00002203;
            6'd9:    return 32'h00420F33;
            6'd10:   return 32'h0000006F;
            default: return 32'h00000013;
        endcase
    endfunction

    assign iidx  = 6'(32'(pc_q[7:2]) % IMEM_WORDS);
    assign instr = rom_word(iidx);
    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1_v = rs1 == 5'd0 ? 32'b0 : regs_q[rs1];
    assign rs2_v = rs2 == 5'd0 ? 32'b0 : regs_q[rs2];
    assign didx  = DW'(32'(alu_y[6:2]) % DMEM_WORDS);
    assign rdata = dmem_q[didx];
    assign out   = out_q;

    rv_alu u_alu (.a(rs1_v), .b(alu_b), .op(alu_op), .y(alu_y), .zero(zero));

    always_comb begin
        alu_b  = rs2_v;
        alu_op = ALU_ADD;
        rf_we  = 1'b0;
        dm_we  = 1'b0;
        wb     = alu_y;
        pc_d   = pc_q + 32'd4;
        case (opc)
            OP_R: begin
                // Only the six supported R-type combinations write back; anything else is a NOP.
                rf_we  = (f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_XOR ||
                          f3 == F3_OR || f3 == F3_AND)) || (f7 == F7_SUB && f3 == F3_ADD);
                alu_op = f7 == F7_SUB ? ALU_SUB : f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR :
                         f3 == F3_XOR ? ALU_XOR : f3 == F3_SLT ? ALU_SLT : ALU_ADD;
            end
            OP_I: begin
                alu_b = imm_i;
                rf_we = f3 == F3_ADD;
            end
            OP_LOAD: begin
                alu_b = imm_i;
                rf_we = f3 == F3_W;
                wb    = rdata;
            end
            OP_STORE: begin
                alu_b = imm_s;
                dm_we = f3 == F3_W;
            end
            OP_BRANCH: begin
                alu_op = ALU_SUB;
                pc_d   = (f3 == F3_BEQ && zero) || (f3 == F3_BNE && !zero) ? pc_q + imm_b : pc_q + 32'd4;
            end
            OP_JAL: begin
                rf_we = 1'b1;
                wb    = pc_q + 32'd4;
                pc_d  = pc_q + imm_j;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            out_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (rf_we && rd != 5'd0) regs_q[rd] <= wb;
            if (rf_we && rd == 5'd30) out_q <= wb[9:0];
        end
    end

    // Data RAM is not cleared by reset; stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (dm_we && reset) dmem_q[didx] <= rs2_v;
    end
endmodule

// File: tb/tb_rv_cpu_core.sv
// tb_rv_cpu_core: directed self-checking bench for rv_cpu_core and rv_alu
module tb_rv_cpu_core;
    import rv_cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] out;
    int         checks = 0;
    int         errors = 0;

    logic [31:0] ta, tb_b, ty;
    logic [2:0]  top;
    logic        tz;

    rv_cpu_core #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (.clk(clk), .reset(reset), .out(out));
    rv_alu u_alu_tb (.a(ta), .b(tb_b), .op(top), .y(ty), .zero(tz));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        ta = '0; tb_b = '0; top = ALU_ADD;
        #2;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_pc", dut.pc_q, 32'd0);
        for (int i = 0; i < 5; i++) begin
            edges(1);
            chk("hold_out", 32'(out), 32'd0);
            chk("hold_pc", dut.pc_q, 32'd0);
        end
        reset = 1'b1;
        edges(5);
        chk("e5", 32'(out), 32'd0);
        edges(1);
        chk("e6", 32'(out), 32'd1);
        edges(4);
        chk("e10", 32'(out), 32'd3);
        edges(4);
        chk("e14", 32'(out), 32'd6);
        edges(4);
        chk("e18", 32'(out), 32'd10);
        edges(24);
        chk("e42", 32'(out), 32'd55);
        edges(3);
        chk("e45", 32'(out), 32'd55);
        edges(1);
        chk("e46", 32'(out), 32'd110);
        for (int e = 47; e <= 100; e++) begin
            edges(1);
            chk("halt", 32'(out), 32'd110);
        end
        chk("halt_pc", dut.pc_q, 32'd40);

        reset = 1'b0;
        #1;
        chk("rst2_out", 32'(out), 32'd0);
        chk("rst2_pc", dut.pc_q, 32'd0);
        reset = 1'b1;
        edges(20);
        chk("r_e20", 32'(out), 32'd10);
        reset = 1'b0;
        #1;
        chk("async_out", 32'(out), 32'd0);
        chk("async_pc", dut.pc_q, 32'd0);
        chk("async_x1", dut.regs_q[1], 32'd0);
        edges(3);
        chk("held_out", 32'(out), 32'd0);
        chk("held_pc", dut.pc_q, 32'd0);
        reset = 1'b1;
        edges(5);
        chk("re_e5", 32'(out), 32'd0);
        edges(1);
        chk("re_e6", 32'(out), 32'd1);
        edges(4);
        chk("re_e10", 32'(out), 32'd3);
        edges(36);
        chk("re_e46", 32'(out), 32'd110);

        force dut.instr = 32'h00500013;
        edges(1);
        force dut.instr = 32'h00000F33;
        edges(1);
        release dut.instr;
        chk("x0_out", 32'(out), 32'd0);
        chk("x0_reg", dut.regs_q[0], 32'd0);

        ta = 32'd3; tb_b = 32'd5; top = ALU_SUB; #1;
        chk("alu_sub", ty, 32'hFFFFFFFE);
        chk("alu_sub_z", 32'(tz), 32'd0);
        ta = 32'hFFFFFFFF; tb_b = 32'd1; top = ALU_SLT; #1;
        chk("alu_slt", ty, 32'd1);
        ta = 32'h1; tb_b = 32'hFFFFFFFF; top = ALU_SLT; #1;
        chk("alu_slt_n", ty, 32'd0);
        ta = 32'hF0; tb_b = 32'hFF; top = ALU_XOR; #1;
        chk("alu_xor", ty, 32'h0F);
        ta = 32'hFFFFFFFF; tb_b = 32'd1; top = ALU_ADD; #1;
        chk("alu_add", ty, 32'd0);
        chk("alu_add_z", 32'(tz), 32'd1);
        ta = 32'hF0; tb_b = 32'h3C; top = ALU_AND; #1;
        chk("alu_and", ty, 32'h30);
        top = ALU_OR; #1;
        chk("alu_or", ty, 32'hFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_cpu_core.md
RV_CPU_CORE -- requirements
Module: rv_cpu_core

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 means held in reset, 1 means running.
REQ-003 The module SHALL have port out, output, 10 bits: registered copy of bits [9:0] of register x30.
REQ-004 The module SHALL have parameter IMEM_WORDS, default 64: depth of the instruction ROM in 32-bit words.
REQ-005 The module SHALL have parameter DMEM_WORDS, default 32: depth of the data RAM in 32-bit words.

Function
REQ-006 The core SHALL be a single-cycle RV32I-subset CPU that executes one instruction per rising clk edge while reset=1.
REQ-007 The core SHALL support ADD, SUB, AND, OR, XOR, SLT, ADDI, LW, SW, BEQ, BNE and JAL with standard RV32I encodings and semantics.
REQ-008 Any other opcode SHALL execute as a NOP: no register or memory write, and PC+4.
REQ-009 The core SHALL have a 32x32 register file; x0 SHALL read as 0, and writes to x0 SHALL be discarded.
REQ-010 The core SHALL perform all arithmetic in 32 bits with wrap-around; SLT SHALL be a signed compare; immediates SHALL be sign-extended.
REQ-011 Instruction and data memories SHALL be word-addressed using PC[7:2] and addr[6:2]; out-of-range indices SHALL wrap modulo depth.
REQ-012 LW SHALL read data memory combinationally; SW SHALL write it on the clock edge.
REQ-013 Taken branches and JAL SHALL load PC+imm; JAL SHALL write PC+4 to rd.
REQ-014 out SHALL update on the same edge that writes x30 and SHALL hold otherwise.
REQ-015 The instruction ROM SHALL hold this fixed program, with all remaining words set to NOP:
  - 0: addi x1,x0,0
  - 1: addi x2,x0,1
  - 2: addi x3,x0,11
  - 3: add x1,x1,x2
  - 4: addi x2,x2,1
  - 5: add x30,x1,x0
  - 6: bne x2,x3,-12
  - 7: sw x1,0(x0)
  - 8: lw x4,0(x0)
  - 9: add x30,x4,x4
  - 10: jal x0,0
REQ-016 Word 10 SHALL be a self-loop that halts the program, after which out SHALL remain constant.

Reset
REQ-017 When reset=0, the core SHALL immediately (asynchronously) set PC=0, out=0 and all registers to 0; data memory contents need not be cleared.
REQ-018 Deasserting reset mid-program SHALL restart execution from word 0 on the first rising edge after deassertion.

Structure
REQ-019 Opcode, funct3 and funct7 constants and the ALU-operation enumeration SHALL live in the shared package rv_cpu_pkg.
REQ-020 The ALU SHALL be the single sub-module rv_alu, with inputs a[31:0], b[31:0] and op, and outputs y[31:0] and zero; everything else SHALL be in the top level.

Verification
REQ-021 Hold reset=0 for 5 cycles -> out=0 and PC=0 throughout, with no change on clk edges.
REQ-022 Release reset and count edges -> out=1 after edge 6, 3 after edge 10, 6 after edge 14, and 4k(k+1)/8 pattern (sum 1..k) after edge 4k+2.
REQ-023 Continue -> out=55 after edge 42, out=110 (0b0001101110) after edge 46, and out stable at 110 through edge 100.
REQ-024 Assert reset at edge 20 for 3 cycles, then release -> out=0 immediately on assertion, then the sequence of REQ-022 restarts from edge 1.
REQ-025 Check x0 after a forced ROM variant "addi x0,x0,5; add x30,x0,x0" -> out=0.
REQ-026 Directed ALU unit test: SUB 3-5 -> 0xFFFFFFFE; SLT -1<1 -> 1; XOR 0xF0^0xFF -> 0x0F; ADD 0xFFFFFFFF+1 -> 0 with zero=1.
